// File: rtl/fifo_byte_packer_pkg.sv
// Shared FIFO helper definitions: word geometry, writer FSM states and the
// byte-lane insert used by the byte packer.
package fifo_byte_packer_pkg;

    localparam int FIFO_WORD_W         = 32;
    localparam int FIFO_BYTES_PER_WORD = 4;
    localparam int FIFO_LANE_W         = 2;

    typedef enum logic [1:0] {
        Writer_IDLE  = 2'd0,
        Writer_PACK  = 2'd1,
        Writer_WRITE = 2'd2
    } FIFO_Writer_Help_state;

    // Drop one byte into its lane; on the word-closing byte, every lane above
    // it is overwritten with the pad value so a short final word is defined.
    function automatic logic [FIFO_WORD_W-1:0] pack_lane(
        input logic [FIFO_WORD_W-1:0] word,
        input logic [FIFO_LANE_W-1:0] lane,
        input logic [7:0]             data,
        input logic                   last,
        input logic [7:0]             pad
    );
        logic [FIFO_WORD_W-1:0] res;
        res = word;
        res[lane*8 +: 8] = data;
        if (last) begin
            for (int k = 0; k < FIFO_BYTES_PER_WORD; k++) begin
                if (k > int'(lane)) begin
                    res[k*8 +: 8] = pad;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_byte_packer.sv
// Packs a byte stream of programmed length little-endian into 32-bit words
// and pushes each word into the shared FIFO; the final word is padded.
module fifo_byte_packer
    import fifo_byte_packer_pkg::*;
#(
    parameter int         LEN_W    = 6,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic                   i_start,
    input  logic [LEN_W-1:0]       i_length,
    input  logic [7:0]             i_byte,
    input  logic                   i_byte_valid,
    output logic                   o_byte_ready,
    input  logic                   i_FIFO_full,
    output logic [FIFO_WORD_W-1:0] o_FIFO_din,
    output logic                   o_FIFO_wr_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [LEN_W-1:0]       o_Bytes_Counter,
    output logic [LEN_W-2:0]       o_Words_Counter
);

    localparam logic [LEN_W-1:0] BYTES_ONE = 1;
    localparam logic [LEN_W-2:0] WORDS_ONE = 1;
    localparam logic [FIFO_LANE_W-1:0] LANE_LAST = FIFO_LANE_W'(FIFO_BYTES_PER_WORD - 1);

    FIFO_Writer_Help_state   state;
    logic [FIFO_WORD_W-1:0]  word_q;
    logic [FIFO_LANE_W-1:0]  lane_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        bytes_q;
    logic [LEN_W-2:0]        words_q;
    logic                    done_q;

    logic [LEN_W-1:0]        bytes_inc;
    logic                    last_byte;
    logic                    wr_fire;
    logic                    msg_end;

    assign bytes_inc = bytes_q + BYTES_ONE;
    // A word closes on its fourth lane or on the message's final byte.
    assign last_byte = (lane_q == LANE_LAST) || (bytes_inc == len_q);
    assign wr_fire   = (state == Writer_WRITE) && !i_FIFO_full;
    assign msg_end   = (bytes_q == len_q);

    assign o_byte_ready    = (state == Writer_PACK);
    assign o_FIFO_wr_en    = wr_fire;
    assign o_FIFO_din      = word_q;
    assign o_busy          = (state != Writer_IDLE);
    assign o_done          = done_q;
    assign o_Bytes_Counter = bytes_q;
    assign o_Words_Counter = words_q;

    // Writer FSM: accept a start, pack bytes into lanes, hand each word to the FIFO.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= Writer_IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            len_q   <= '0;
            bytes_q <= '0;
            words_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                Writer_IDLE: begin
                    if (i_start && (i_length != '0)) begin
                        len_q   <= i_length;
                        word_q  <= '0;
                        lane_q  <= '0;
                        bytes_q <= '0;
                        words_q <= '0;
                        state   <= Writer_PACK;
                    end
                end
                Writer_PACK: begin
                    if (i_byte_valid) begin
                        word_q  <= pack_lane(word_q, lane_q, i_byte, last_byte, PAD_BYTE);
                        lane_q  <= lane_q + 1'b1;
                        bytes_q <= bytes_inc;
                        if (last_byte) begin
                            state <= Writer_WRITE;
                        end
                    end
                end
                Writer_WRITE: begin
                    if (wr_fire) begin
                        words_q <= words_q + WORDS_ONE;
                        if (msg_end) begin
                            state  <= Writer_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            word_q <= '0;
                            lane_q <= '0;
                            state  <= Writer_PACK;
                        end
                    end
                end
                default: begin
                    state <= Writer_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: hand-computed words, counters and timing.
module tb_fifo_byte_packer;

    localparam int LEN_W = 6;

    logic              CLK = 1'b0;
    logic              RESETn;
    logic              i_start;
    logic [LEN_W-1:0]  i_length;
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic              i_FIFO_full;
    logic [31:0]       o_FIFO_din;
    logic              o_FIFO_wr_en;
    logic              o_busy;
    logic              o_done;
    logic [LEN_W-1:0]  o_Bytes_Counter;
    logic [LEN_W-2:0]  o_Words_Counter;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [31:0] wr_q[$];
    int          wr_cyc[$];

    fifo_byte_packer #(.LEN_W(LEN_W), .PAD_BYTE(8'h00)) dut (
        .CLK             (CLK),
        .RESETn          (RESETn),
        .i_start         (i_start),
        .i_length        (i_length),
        .i_byte          (i_byte),
        .i_byte_valid    (i_byte_valid),
        .o_byte_ready    (o_byte_ready),
        .i_FIFO_full     (i_FIFO_full),
        .o_FIFO_din      (o_FIFO_din),
        .o_FIFO_wr_en    (o_FIFO_wr_en),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_Bytes_Counter (o_Bytes_Counter),
        .o_Words_Counter (o_Words_Counter)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every FIFO write and done pulse, sampled mid-low-phase.
    always @(negedge CLK) begin
        #2;
        if (o_FIFO_wr_en) begin
            wr_q.push_back(o_FIFO_din);
            wr_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input logic [LEN_W-1:0] len);
        i_start  = 1'b1;
        i_length = len;
        @(negedge CLK);
        i_start  = 1'b0;
    endtask

    task automatic feed(input int n, input logic [7:0] first, input bit toggle);
        int t;
        for (int i = 0; i < n; i++) begin
            i_byte       = first + 8'(i);
            i_byte_valid = 1'b1;
            t = 0;
            while (!o_byte_ready && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 50) begin
                check("feed_timeout", 32'd1, 32'd0);
                i_byte_valid = 1'b0;
                return;
            end
            @(negedge CLK);
            if (toggle) begin
                i_byte_valid = 1'b0;
                @(negedge CLK);
            end
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (o_busy && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check(tag, 32'd1, 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        int d0;
        RESETn       = 1'b0;
        i_start      = 1'b0;
        i_length     = '0;
        i_byte       = '0;
        i_byte_valid = 1'b0;
        i_FIFO_full  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(o_byte_ready), 32'd0);
        check("rst_wr_en", 32'(o_FIFO_wr_en), 32'd0);
        check("rst_din",   o_FIFO_din,        32'h0);
        check("rst_busy",  32'(o_busy),       32'd0);
        check("rst_done",  32'(o_done),       32'd0);
        check("rst_bytes", 32'(o_Bytes_Counter), 32'd0);
        check("rst_words", 32'(o_Words_Counter), 32'd0);
        RESETn = 1'b1;
        @(negedge CLK);

        // length 8, contiguous bytes
        wr_q.delete(); wr_cyc.delete(); d0 = done_cnt;
        start_msg(6'd8);
        feed(8, 8'h01, 1'b0);
        wait_idle("t1_timeout");
        check("t1_nwr",  32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            check("t1_w0",   wr_q[0], 32'h04030201);
            check("t1_w1",   wr_q[1], 32'h08070605);
            check("t1_gap",  32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
            check("t1_done_lat", 32'(done_cyc - wr_cyc[1]), 32'd1);
        end
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_words", 32'(o_Words_Counter), 32'd2);
        check("t1_bytes", 32'(o_Bytes_Counter), 32'd8);

        // length 5, padded final word
        wr_q.delete(); wr_cyc.delete(); d0 = done_cnt;
        start_msg(6'd5);
        feed(5, 8'h11, 1'b0);
        wait_idle("t2_timeout");
        check("t2_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            check("t2_w0", wr_q[0], 32'h14131211);
            check("t2_w1", wr_q[1], 32'h00000015);
        end
        check("t2_done",  32'(done_cnt - d0), 32'd1);
        check("t2_words", 32'(o_Words_Counter), 32'd2);

        // length 4, FIFO full for the first 3 WRITE cycles
        wr_q.delete(); wr_cyc.delete(); d0 = done_cnt;
        i_FIFO_full = 1'b1;
        start_msg(6'd4);
        feed(4, 8'h01, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("t3_stall_wr",    32'(o_FIFO_wr_en), 32'd0);
            check("t3_stall_din",   o_FIFO_din,        32'h04030201);
            check("t3_stall_ready", 32'(o_byte_ready), 32'd0);
            @(negedge CLK);
        end
        i_FIFO_full = 1'b0;
        #1;
        check("t3_wr_now", 32'(o_FIFO_wr_en), 32'd1);
        @(negedge CLK);
        #3;
        check("t3_done_pulse", 32'(o_done), 32'd1);
        wait_idle("t3_timeout");
        check("t3_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) check("t3_w0", wr_q[0], 32'h04030201);
        check("t3_done", 32'(done_cnt - d0), 32'd1);

        // length 6, toggling valid
        wr_q.delete(); wr_cyc.delete(); d0 = done_cnt;
        start_msg(6'd6);
        feed(6, 8'h01, 1'b1);
        wait_idle("t4_timeout");
        check("t4_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            check("t4_w0", wr_q[0], 32'h04030201);
            check("t4_w1", wr_q[1], 32'h00000605);
        end
        check("t4_bytes", 32'(o_Bytes_Counter), 32'd6);
        check("t4_done",  32'(done_cnt - d0), 32'd1);

        // zero length ignored; start while busy ignored
        wr_q.delete(); wr_cyc.delete(); d0 = done_cnt;
        start_msg(6'd0);
        check("t5_zero_busy", 32'(o_busy), 32'd0);
        @(negedge CLK);
        check("t5_zero_busy2", 32'(o_busy), 32'd0);
        check("t5_zero_done", 32'(done_cnt - d0), 32'd0);
        start_msg(6'd3);
        check("t5_busy", 32'(o_busy), 32'd1);
        start_msg(6'd9);
        feed(3, 8'h01, 1'b0);
        wait_idle("t5_timeout");
        check("t5_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) check("t5_w0", wr_q[0], 32'h00030201);
        check("t5_bytes", 32'(o_Bytes_Counter), 32'd3);
        check("t5_words", 32'(o_Words_Counter), 32'd1);
        check("t5_done",  32'(done_cnt - d0), 32'd1);

        // reset mid-message, then a fresh message
        wr_q.delete(); wr_cyc.delete(); d0 = done_cnt;
        start_msg(6'd8);
        feed(2, 8'h01, 1'b0);
        RESETn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        check("t6_ready", 32'(o_byte_ready), 32'd0);
        check("t6_wr_en", 32'(o_FIFO_wr_en), 32'd0);
        check("t6_din",   o_FIFO_din,        32'h0);
        check("t6_busy",  32'(o_busy),       32'd0);
        check("t6_bytes", 32'(o_Bytes_Counter), 32'd0);
        @(negedge CLK);
        check("t6_nwr_rst", 32'(wr_q.size()), 32'd0);
        start_msg(6'd4);
        feed(4, 8'h21, 1'b0);
        wait_idle("t6_timeout");
        check("t6_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) check("t6_w0", wr_q[0], 32'h24232221);
        check("t6_words", 32'(o_Words_Counter), 32'd1);
        check("t6_done",  32'(done_cnt - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_byte_packer.md
Name: fifo_byte_packer

Overview:
Upstream stage of the FIFO reader helper. It takes a byte stream of a programmed length and packs it little-endian into 32-bit words: byte 0 goes in [7:0], byte 3 in [31:24]. It writes each word into the shared 32-bit FIFO, and a partial final word is padded. This guarantees the downstream serializer sees ceil(length/4) words with bytes in order.

Parameters:
LEN_W, 6, width of message length and byte counter (max message 2^LEN_W-1 bytes)
PAD_BYTE, 8'h00, fill value for unused lanes of the final word

Ports:
CLK  input  1  clock, rising edge
RESETn  input  1  synchronous, active-low reset
i_start  input  1  one-cycle request to begin a message; sampled only in IDLE
i_length  input  LEN_W  message length in bytes, latched on accepted i_start
i_byte  input  8  input byte
i_byte_valid  input  1  i_byte is valid
o_byte_ready  output  1  block accepts i_byte this cycle
i_FIFO_full  input  1  FIFO full flag
o_FIFO_din  output  32  word to FIFO
o_FIFO_wr_en  output  1  FIFO write strobe
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle pulse after final word written
o_Bytes_Counter  output  LEN_W  bytes accepted in current message
o_Words_Counter  output  LEN_W-1  words written in current message

Behaviour:
- Reset (RESETn=0 at posedge): state IDLE; word register = 0; lane = 0; counters = 0; latched length = 0; o_done = 0. Outputs during/after reset: o_byte_ready=0, o_FIFO_wr_en=0, o_FIFO_din=0, o_busy=0.
- Reset mid-message: abandon the message immediately. No partial word is written.
- States: IDLE, PACK, WRITE.
- IDLE:
  - i_start=1 with i_length!=0: latch length; clear word register, lane, both counters; go to PACK next cycle.
  - i_start with i_length=0: ignored, no write, no done.
  - i_byte_valid in IDLE: ignored.
- PACK:
  - o_byte_ready=1 (combinational, state only).
  - On i_byte_valid: write i_byte into lane `lane`; lane+1; o_Bytes_Counter+1.
  - Go to WRITE if lane==3 or the accepted byte is byte number length (o_Bytes_Counter+1==length). On that transition, lanes above the current one are set to PAD_BYTE.
  - No valid: hold.
- WRITE:
  - o_byte_ready=0.
  - o_FIFO_din = word register, stable for the whole state.
  - o_FIFO_wr_en = !i_FIFO_full (combinational). The block never writes when full.
  - When wr_en=1:
    - o_Words_Counter+1.
    - If o_Bytes_Counter==length: go to IDLE and pulse o_done in the next cycle.
    - Else: clear word register and lane, return to PACK.
- Latency:
  - Word-completing byte accepted at cycle N → wr_en at N+1 if not full.
  - Throughput is 4 bytes per 5 cycles at best (one write cycle per word).
- Counters:
  - o_Bytes_Counter and o_Words_Counter hold their final values in IDLE until the next accepted i_start.
  - Words written = ceil(length/4) exactly.
- i_start while busy: ignored. i_length changes while busy have no effect.
- Simultaneous i_FIFO_full deassert and WRITE entry: the write occurs the same cycle full is low.

Decomposition:
- ahb3lite_pkg gains enum FIFO_Writer_Help_state {Writer_IDLE, Writer_PACK, Writer_WRITE}.
- Shared constant for FIFO word width (32) and bytes-per-word (4) belongs in the package, alongside the reader helper's values.
- No sub-module. Lane insert is a single indexed part-select on the word register.

Test Plan:
1. length=8, bytes 01..08 contiguous, full=0 → two writes 0x04030201 then 0x08070605, one cycle apart plus one pack gap; o_done one cycle after second write; Words_Counter=2, Bytes_Counter=8.
2. length=5, bytes 11..15 → writes 0x14131211 then 0x00000015; done; Words_Counter=2.
3. length=4, FIFO full held 3 cycles when WRITE entered → wr_en=0 for 3 cycles, o_FIFO_din=0x04030201 stable, o_byte_ready=0; write on cycle 4; done next cycle.
4. length=6, i_byte_valid toggling 1/0 → each byte accepted only on valid&ready; words 0x04030201, 0x00000605; no byte dropped or duplicated.
5. length=0 start → no state change, no wr_en, no done. Then start length=3 while busy with a second start length=9 → second ignored; single write 0x00030201 (bytes 01..03).
6. RESETn low after 2 bytes of length=8 message → no wr_en ever; after release, all outputs 0. A new length=4 message packs correctly from lane 0.
